load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 42 ++++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory signal bundle for the load/store unit
interface load_store_unit_if;
    // Request channel
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqUnsigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    // Response channel
    logic        RespValid;
    logic        RespReady;
    logic [31:0] RespData;
    logic        RespErr;
    // Data-memory port
    logic [31:0] MemAddr;
    logic [31:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] MemReadData;

    // The load/store unit itself
    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqWData,
        output ReqReady,
        output RespValid, RespData, RespErr,
        input  RespReady,
        output MemAddr, MemWriteData, MemWrite, MemRead,
        input  MemReadData
    );

    // The requester plus the data memory
    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqWData,
        input  ReqReady,
        input  RespValid, RespData, RespErr,
        output RespReady,
        input  MemAddr, MemWriteData, MemWrite, MemRead,
        output MemReadData
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with byte/half read-modify-write; optional LSU_MISALIGN_TRAP_EN
module load_store_unit (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, RESP} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic        unsigned_q, unsigned_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

`ifdef LSU_MISALIGN_TRAP_EN
    logic        err_q, err_d;

    // Misaligned half/word requests short-circuit straight to an error response
    assign misalign = ((bus.ReqSize == 2'b01) && bus.ReqAddr[0]) ||
                      (bus.ReqSize[1] && (bus.ReqAddr[1:0] != 2'b00));
    assign bus.RespErr = err_q;

    // Error flag is captured at accept and held through the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
`else
    // Misaligned low bits are simply ignored by the lane selection below
    assign misalign    = 1'b0;
    assign bus.RespErr = 1'b0;
`endif

    assign bus.MemAddr  = {2'b00, addr_q[31:2]};
    assign bus.RespData = rdata_q;

    // Lane extraction and sign/zero extension of the loaded word
    always_comb begin
        load_byte = 8'h00;
        case (addr_q[1:0])
            2'b00:   load_byte = bus.MemReadData[7:0];
            2'b01:   load_byte = bus.MemReadData[15:8];
            2'b10:   load_byte = bus.MemReadData[23:16];
            default: load_byte = bus.MemReadData[31:24];
        endcase
        load_half = addr_q[1] ? bus.MemReadData[31:16] : bus.MemReadData[15:0];
        load_ext  = bus.MemReadData;
        if (size_q == 2'b00)
            load_ext = unsigned_q ? {24'h0, load_byte} : {{24{load_byte[7]}}, load_byte};
        else if (size_q == 2'b01)
            load_ext = unsigned_q ? {16'h0, load_half} : {{16{load_half[15]}}, load_half};
    end

    // Store word: full word, or the RMW buffer with the addressed lane replaced
    always_comb begin
        merged = merge_q;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            merge_q    <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            unsigned_q <= unsigned_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            merge_q    <= merge_d;
            rdata_q    <= rdata_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        unsigned_d       = unsigned_q;
        size_d           = size_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        merge_d          = merge_q;
        rdata_d          = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        err_d            = err_q;
`endif
        bus.ReqReady     = 1'b0;
        bus.RespValid    = 1'b0;
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.MemWriteData = 32'h0;
        case (state_q)
            IDLE: begin
                bus.ReqReady = 1'b1;
                if (bus.ReqValid) begin
                    write_d    = bus.ReqWrite;
                    unsigned_d = bus.ReqUnsigned;
                    size_d     = bus.ReqSize;
                    addr_d     = bus.ReqAddr;
                    wdata_d    = bus.ReqWData;
                    rdata_d    = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
                    err_d      = misalign;
`endif
                    if (misalign)          state_d = RESP;
                    else if (!bus.ReqWrite) state_d = LOAD;
                    else if (bus.ReqSize[1]) state_d = STORE;
                    else                   state_d = RMW_RD;
                end
            end
            LOAD: begin
                bus.MemRead = 1'b1;
                rdata_d     = load_ext;
                state_d     = RESP;
            end
            RMW_RD: begin
                bus.MemRead = 1'b1;
                merge_d     = bus.MemReadData;
                state_d     = STORE;
            end
            STORE: begin
                bus.MemWrite     = 1'b1;
                bus.MemWriteData = merged;
                state_d          = RESP;
            end
            RESP: begin
                bus.RespValid = 1'b1;
                if (bus.RespReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit against a behavioural model
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Bench data memory (16 words, upper address bits alias)
    logic [31:0] mem [0:15];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'h0;
    logic [31:0] pl_val = 32'h0;

    assign bus.MemReadData = mem[bus.MemAddr[3:0]];

    always @(posedge clk) begin
        if (pl_en)             mem[pl_idx] <= pl_val;
        else if (bus.MemWrite) mem[bus.MemAddr[3:0]] <= bus.MemWriteData;
    end

    // Reference memory image kept by the model
    logic [31:0] ref_mem [0:15];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                               input logic u, input logic [31:0] a);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (word >> (8 * int'(a[1:0]))) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (word >> (16 * int'(a[1]))) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] sz,
                                                input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (sz == 2'b00) begin
            sh   = 8 * int'(a[1:0]);
            mask = 32'hFF << sh;
            return (old & ~mask) | ((wd & 32'hFF) << sh);
        end else if (sz == 2'b01) begin
            sh   = 16 * int'(a[1]);
            mask = 32'hFFFF << sh;
            return (old & ~mask) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = idx[3:0];
        pl_val = val;
        @(posedge clk);
        #1 pl_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input int stall,
                          output logic [31:0] got_data);
        int          idx, lat, exp_lat, nrd, nwr, nboth, exp_rd, exp_wr;
        logic        mis;
        logic [31:0] exp_data, exp_wdata, wr_data, wr_addr, exp_waddr;
        idx       = int'(a[5:2]);
        mis       = TRAP && (((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00)));
        exp_lat   = mis ? 1 : ((!w || sz[1]) ? 2 : 3);
        exp_rd    = mis ? 0 : ((!w) ? 1 : (sz[1] ? 0 : 1));
        exp_wr    = (!mis && w) ? 1 : 0;
        exp_data  = (mis || w) ? 32'h0 : model_load(ref_mem[idx], sz, u, a);
        exp_wdata = (exp_wr == 1) ? model_store(ref_mem[idx], sz, a, wd) : 32'h0;
        exp_waddr = (exp_wr == 1) ? {2'b00, a[31:2]} : 32'h0;
        if (exp_wr == 1) ref_mem[idx] = exp_wdata;

        @(negedge clk);
        check("req_ready_idle", {31'h0, bus.ReqReady}, 32'h1);
        bus.ReqValid    = 1'b1;
        bus.ReqWrite    = w;
        bus.ReqSize     = sz;
        bus.ReqUnsigned = u;
        bus.ReqAddr     = a;
        bus.ReqWData    = wd;
        @(posedge clk);
        #1 bus.ReqValid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; nboth = 0;
        wr_data = 32'h0; wr_addr = 32'h0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (bus.RespValid) break;
            if (bus.MemRead && bus.MemWrite) nboth++;
            if (bus.MemRead) nrd++;
            if (bus.MemWrite) begin
                nwr++;
                wr_data = bus.MemWriteData;
                wr_addr = bus.MemAddr;
            end
        end
        got_data = bus.RespData;
        check("latency", lat, exp_lat);
        check("mem_reads", nrd, exp_rd);
        check("mem_writes", nwr, exp_wr);
        check("rd_wr_overlap", nboth, 0);
        check("write_data", wr_data, exp_wdata);
        check("write_addr", wr_addr, exp_waddr);
        check("resp_data", bus.RespData, exp_data);
        check("resp_err", {31'h0, bus.RespErr}, {31'h0, mis});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", {31'h0, bus.RespValid}, 32'h1);
            check("stall_data", bus.RespData, exp_data);
            check("stall_err", {31'h0, bus.RespErr}, {31'h0, mis});
            check("stall_ready", {31'h0, bus.ReqReady}, 32'h0);
            check("stall_mem", {30'h0, bus.MemRead, bus.MemWrite}, 32'h0);
        end
        bus.RespReady = 1'b1;
        @(posedge clk);
        #1 bus.RespReady = 1'b0;
    endtask

    logic [31:0] got;

    initial begin
        bus.ReqValid    = 1'b0;
        bus.ReqWrite    = 1'b0;
        bus.ReqSize     = 2'b00;
        bus.ReqUnsigned = 1'b0;
        bus.ReqAddr     = 32'h0;
        bus.ReqWData    = 32'h0;
        bus.RespReady   = 1'b0;
        rst_n           = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'h0, bus.ReqReady}, 32'h1);
        check("rst_resp_valid", {31'h0, bus.RespValid}, 32'h0);
        check("rst_resp_data", bus.RespData, 32'h0);
        check("rst_resp_err", {31'h0, bus.RespErr}, 32'h0);
        check("rst_mem_read", {31'h0, bus.MemRead}, 32'h0);
        check("rst_mem_write", {31'h0, bus.MemWrite}, 32'h0);
        check("rst_mem_addr", bus.MemAddr, 32'h0);
        check("rst_mem_wdata", bus.MemWriteData, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) poke(i, $urandom);

        // Word store then load back
        do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 0, got);
        do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 0, got);
        check("word_roundtrip", got, 32'hDEADBEEF);

        // Signed / unsigned byte load
        poke(2, 32'h1234F680);
        do_req(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 0, got);
        check("byte_signed", got, 32'hFFFFFFF6);
        do_req(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 0, got);
        check("byte_unsigned", got, 32'h000000F6);

        // Half store read-modify-write
        poke(1, 32'hAABBCCDD);
        do_req(1'b1, 2'b01, 1'b0, 32'h6, 32'h1122, 0, got);
        @(negedge clk);
        check("half_rmw_mem", mem[1], 32'h1122CCDD);

        // Backpressure on a load
        do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 5, got);
        check("backpressure_data", got, 32'h1122CCDD);

        // Misaligned word load
        do_req(1'b0, 2'b10, 1'b0, 32'h5, 32'h0, 0, got);
        check("misalign_data", got, TRAP ? 32'h0 : 32'h1122CCDD);

        // Reset during the RMW read of a byte store
        poke(3, 32'h55667788);
        @(negedge clk);
        bus.ReqValid = 1'b1;
        bus.ReqWrite = 1'b1;
        bus.ReqSize  = 2'b00;
        bus.ReqAddr  = 32'hD;
        bus.ReqWData = 32'hAB;
        @(posedge clk);
        #1 bus.ReqValid = 1'b0;
        check("rmw_read_active", {31'h0, bus.MemRead}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_async_read", {31'h0, bus.MemRead}, 32'h0);
        check("rst_async_write", {31'h0, bus.MemWrite}, 32'h0);
        check("rst_async_ready", {31'h0, bus.ReqReady}, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_write", {31'h0, bus.MemWrite}, 32'h0);
            check("post_rst_resp", {31'h0, bus.RespValid}, 32'h0);
            check("post_rst_ready", {31'h0, bus.ReqReady}, 32'h1);
        end
        check("rst_mem_intact", mem[3], 32'h55667788);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom_range(0, 3), got);
        end

        @(negedge clk);
        for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
